counter_load_scheduler: RTL

//   Shares the load port (ld/init) of one loadable up-counter among NREQ requesters.

---
 rtl/counter_load_scheduler.sv | 123 ++++++++++++
 1 files changed

// File: rtl/counter_load_scheduler.sv
// counter_load_scheduler: round-robin sharing of one counter load port among NREQ
// requesters, with a post-load guard gap and an idle-timeout auto-reload.
module counter_load_scheduler #(
    parameter int               NREQ      = 4,
    parameter int               WIDTH     = 16,
    parameter int               MIN_GAP   = 3,
    parameter int               TIMEOUT   = 32,
    parameter logic [WIDTH-1:0] AUTO_INIT = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*WIDTH-1:0]    req_data,
    output logic [NREQ-1:0]          req_ready,
    input  logic [WIDTH-1:0]         ctr_count,
    output logic                     ctr_ld,
    output logic [WIDTH-1:0]         ctr_init,
    output logic [$clog2(NREQ)-1:0]  grant_id,
    output logic                     grant_auto,
    output logic                     busy
);

    // state | meaning
    // IDLE  | arbitrate requests, count idle cycles toward auto-reload
    // LOAD  | ctr_ld high for one cycle with the captured value
    // GAP   | guard interval, no request accepted for MIN_GAP cycles

    localparam int PW = $clog2(NREQ);
    localparam int IW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int GW = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t          state;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   winner;
    logic [PW-1:0]   cand;
    logic [PW-1:0]   ptr_next;
    logic            any_valid;
    logic [NREQ-1:0] grant_vec;
    logic [IW-1:0]   idle_cnt;
    logic [GW-1:0]   gap_cnt;
    logic            timeout_hit;
    logic            unused_count;

    // ctr_count is status-only; it never influences sequencing
    assign unused_count = ^ctr_count;

    // first valid index at or after ptr, wrapping
    always_comb begin
        winner    = ptr;
        cand      = '0;
        any_valid = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            cand = PW'((int'(ptr) + k) % NREQ);
            if (!any_valid && req_valid[cand]) begin
                any_valid = 1'b1;
                winner    = cand;
            end
        end
    end

    assign ptr_next    = (winner == PW'(NREQ - 1)) ? '0 : winner + 1'b1;
    assign grant_vec   = NREQ'(1) << winner;
    assign timeout_hit = (TIMEOUT != 0) && (idle_cnt == IW'(TIMEOUT - 1));

    // gated with rst_n so ready is silent while reset is held
    assign req_ready = (rst_n && (state == IDLE) && any_valid) ? grant_vec : '0;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ptr        <= '0;
            idle_cnt   <= '0;
            gap_cnt    <= '0;
            ctr_ld     <= 1'b0;
            ctr_init   <= '0;
            grant_id   <= '0;
            grant_auto <= 1'b0;
        end else begin
            ctr_ld <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        ctr_ld     <= 1'b1;
                        ctr_init   <= req_data[int'(winner)*WIDTH +: WIDTH];
                        grant_id   <= winner;
                        grant_auto <= 1'b0;
                        ptr        <= ptr_next;
                        idle_cnt   <= '0;
                        state      <= LOAD;
                    end else if (timeout_hit) begin
                        ctr_ld     <= 1'b1;
                        ctr_init   <= AUTO_INIT;
                        grant_auto <= 1'b1;
                        idle_cnt   <= '0;
                        state      <= LOAD;
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end
                LOAD: begin
                    gap_cnt <= '0;
                    state   <= (MIN_GAP > 0) ? GAP : IDLE;
                end
                GAP: begin
                    if (gap_cnt == GW'(MIN_GAP - 1)) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
